// File: rtl/frame_downscaler_if.sv
// Camera FIFO read side and downscaled pixel stream of the frame downscaler.
interface frame_downscaler_if;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_rd;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_href;
   logic       out_vref;

   modport master (
      input  fifo_data, fifo_empty, out_ready,
      output fifo_rd, out_data, out_valid, out_href, out_vref
   );

   modport slave (
      output fifo_data, fifo_empty, out_ready,
      input  fifo_rd, out_data, out_valid, out_href, out_vref
   );
endinterface

// File: rtl/frame_downscaler.sv
// Box-filter downscaler: sums each 2^SCALE_LOG2 square block of camera pixels
// and emits the top byte of every block sum, one band of blocks at a time.
//
// state   | meaning
// IDLE    | waiting for start, outputs quiet
// CAPTURE | reading one band of source lines into the column accumulators
// EMIT    | streaming the band's accumulators out, clearing each on transfer
// DONE    | one-cycle frame_done, then back to IDLE
module frame_downscaler #(
   parameter int SRC_WIDTH  = 736,
   parameter int SRC_HEIGHT = 480,
   parameter int SCALE_LOG2 = 4,
   parameter int WIDTH      = 46,
   parameter int HEIGHT     = 30
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   frame_downscaler_if.master  bus,
   output logic                frame_done,
   output logic                buffer_ready
);

   localparam int BAND_PIX = SRC_WIDTH * (1 << SCALE_LOG2);
   localparam int X_W      = (SRC_WIDTH  > 1) ? $clog2(SRC_WIDTH)  : 1;
   localparam int Y_W      = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;
   localparam int K_W      = (WIDTH      > 1) ? $clog2(WIDTH)      : 1;
   localparam int B_W      = (HEIGHT     > 1) ? $clog2(HEIGHT)     : 1;
   localparam int R_W      = $clog2(BAND_PIX + 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, DONE} state_t;

   state_t         state, state_nxt;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [K_W-1:0] k;
   logic [B_W-1:0] band;
   logic [R_W-1:0] rd_cnt;
   logic           rd_q;
   logic [11:0]    hsum;
   logic [15:0]    acc [WIDTH];

   logic           pix_vld;
   logic           blk_end;
   logic           band_end;
   logic           xfer;
   logic           last_k;
   logic           last_band;
   logic [K_W-1:0] x_blk;

   assign pix_vld   = (state == CAPTURE) && rd_q;
   assign blk_end   = &x[SCALE_LOG2-1:0];
   assign band_end  = pix_vld && (x == X_W'(SRC_WIDTH - 1)) && (&y[SCALE_LOG2-1:0]);
   assign xfer      = (state == EMIT) && bus.out_ready;
   assign last_k    = (k == K_W'(WIDTH - 1));
   assign last_band = (band == B_W'(HEIGHT - 1));
   assign x_blk     = K_W'(x >> SCALE_LOG2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.fifo_rd    = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_href   = 1'b0;
      bus.out_vref   = 1'b0;
      bus.out_data   = '0;
      frame_done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            bus.out_vref = 1'b1;
            // read budget stops the band exactly at its last pixel
            bus.fifo_rd  = !bus.fifo_empty && (rd_cnt < R_W'(BAND_PIX));
            if (band_end) state_nxt = EMIT;
         end
         EMIT: begin
            bus.out_vref  = 1'b1;
            bus.out_href  = 1'b1;
            bus.out_valid = 1'b1;
            bus.out_data  = acc[k][15:8];
            if (xfer && last_k) state_nxt = last_band ? DONE : CAPTURE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x            <= '0;
         y            <= '0;
         k            <= '0;
         band         <= '0;
         rd_cnt       <= '0;
         rd_q         <= 1'b0;
         hsum         <= '0;
         buffer_ready <= 1'b0;
         for (int i = 0; i < WIDTH; i++) acc[i] <= '0;
      end else begin
         rd_q <= bus.fifo_rd;
         case (state)
            IDLE: begin
               if (start) begin
                  x            <= '0;
                  y            <= '0;
                  k            <= '0;
                  band         <= '0;
                  rd_cnt       <= '0;
                  hsum         <= '0;
                  buffer_ready <= 1'b0;
                  for (int i = 0; i < WIDTH; i++) acc[i] <= '0;
               end
            end
            CAPTURE: begin
               if (bus.fifo_rd) rd_cnt <= rd_cnt + R_W'(1);
               if (pix_vld) begin
                  if (blk_end) begin
                     acc[x_blk] <= acc[x_blk] + 16'(hsum) + 16'(bus.fifo_data);
                     hsum       <= '0;
                  end else begin
                     hsum <= hsum + 12'(bus.fifo_data);
                  end
                  if (x == X_W'(SRC_WIDTH - 1)) begin
                     x <= '0;
                     y <= (y == Y_W'(SRC_HEIGHT - 1)) ? '0 : y + Y_W'(1);
                  end else begin
                     x <= x + X_W'(1);
                  end
               end
               if (band_end) rd_cnt <= '0;
            end
            EMIT: begin
               if (xfer) begin
                  acc[k] <= '0;
                  k      <= last_k ? '0 : k + K_W'(1);
                  if (last_k && !last_band) band <= band + B_W'(1);
               end
            end
            DONE: buffer_ready <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_downscaler.sv
// Self-checking bench for frame_downscaler on a reduced 48x48 frame (3x3 output).
module tb_frame_downscaler;
   localparam int SW = 48, SH = 48, SL = 4, W = 3, H = 3;
   localparam int BLK = 1 << SL;
   localparam int NP = SW * SH, NO = W * H;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic frame_done, buffer_ready;

   frame_downscaler_if bus();

   frame_downscaler #(.SRC_WIDTH(SW), .SRC_HEIGHT(SH), .SCALE_LOG2(SL),
                      .WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .frame_done(frame_done), .buffer_ready(buffer_ready));

   always #5 clk = ~clk;

   logic [7:0] pix [NP];
   logic [7:0] exp_q [$];
   logic [7:0] got [$];
   int rd_issued, data_idx;
   bit pend, tog, stl, prev_hold, prev_href;
   logic [7:0] prev_data;
   int empty_mode, ready_mode, stall_left, stall_seen;
   int href_cnt, done_cnt, rd_empty_bad, stab_bad, stall_bad;
   int n_cmp, n_bad;

   // Camera FIFO source, downstream sink and protocol monitor, all at the falling edge.
   initial begin
      bus.fifo_data = '0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (pend && data_idx < NP) begin
            bus.fifo_data = pix[data_idx];
            data_idx++;
         end
         pend = 1'b0;
         tog = !tog;
         case (empty_mode)
            1:       stl = tog;
            2:       stl = 1'($urandom_range(0, 1));
            default: stl = 1'b0;
         endcase
         bus.fifo_empty = (rd_issued >= NP) || stl;
         if (ready_mode == 1)
            bus.out_ready = 1'($urandom_range(0, 1));
         else if (ready_mode == 2)
            bus.out_ready = !(bus.out_valid && stall_left > 0 && got.size() >= 1);
         else
            bus.out_ready = 1'b1;
         #1;
         if (bus.fifo_rd) begin
            if (bus.fifo_empty) rd_empty_bad++;
            rd_issued++;
            pend = 1'b1;
         end
         if (prev_hold && (bus.out_data !== prev_data || bus.out_valid !== 1'b1)) stab_bad++;
         if (ready_mode == 2 && bus.out_valid && !bus.out_ready) begin
            stall_left--;
            stall_seen++;
            if (bus.fifo_rd) stall_bad++;
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_data = bus.out_data;
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         if (bus.out_href && !prev_href) href_cnt++;
         prev_href = bus.out_href;
         if (frame_done) done_cnt++;
      end
   end

   // pattern 0: constant 0x80, 1: block (0,0) white plus top half of block (1,0), 2: random
   task automatic src_load(input int pattern);
      int sum;
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++) begin
            case (pattern)
               0:       pix[r*SW+c] = 8'h80;
               1:       pix[r*SW+c] = ((r < 16 && c < 16) || (r < 8 && c >= 16 && c < 32)) ? 8'hFF : 8'h00;
               default: pix[r*SW+c] = 8'($urandom_range(0, 255));
            endcase
         end
      exp_q.delete();
      for (int br = 0; br < H; br++)
         for (int bc = 0; bc < W; bc++) begin
            sum = 0;
            for (int rr = 0; rr < BLK; rr++)
               for (int cc = 0; cc < BLK; cc++)
                  sum += int'(pix[(br*BLK+rr)*SW + bc*BLK + cc]);
            exp_q.push_back(8'(sum / 256));
         end
      rd_issued = 0; data_idx = 0; pend = 1'b0; got.delete();
      href_cnt = 0; done_cnt = 0; rd_empty_bad = 0; stab_bad = 0; stall_bad = 0;
      stall_seen = 0; prev_hold = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30000 && done_cnt == 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      n_cmp++; if (bus.fifo_rd !== 1'b0)      begin n_bad++; $display("FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); end
      n_cmp++; if (bus.out_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_href !== 1'b0)     begin n_bad++; $display("FAIL reset_out_href: got %b want 0", bus.out_href); end
      n_cmp++; if (bus.out_vref !== 1'b0)     begin n_bad++; $display("FAIL reset_out_vref: got %b want 0", bus.out_vref); end
      n_cmp++; if (bus.out_data !== 8'h00)    begin n_bad++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
      n_cmp++; if (frame_done !== 1'b0)       begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_cmp++; if (buffer_ready !== 1'b0)     begin n_bad++; $display("FAIL reset_buffer_ready: got %b want 0", buffer_ready); end
      @(negedge clk); reset = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      n_cmp++; if (bus.fifo_rd !== 1'b0)      begin n_bad++; $display("FAIL idle_fifo_rd: got %b want 0", bus.fifo_rd); end
      n_cmp++; if (bus.out_vref !== 1'b0)     begin n_bad++; $display("FAIL idle_out_vref: got %b want 0", bus.out_vref); end
   endtask

   task automatic test_constant();
      src_load(0); empty_mode = 0; ready_mode = 0;
      pulse_start();
      #2;
      n_cmp++; if (bus.out_vref !== 1'b1) begin n_bad++; $display("FAIL const_vref_start: got %b want 1", bus.out_vref); end
      wait_done();
      n_cmp++; if (got.size() !== NO) begin n_bad++; $display("FAIL const_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL const_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (href_cnt !== H)        begin n_bad++; $display("FAIL const_href: got %0d want %0d", href_cnt, H); end
      n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL const_done: got %0d want 1", done_cnt); end
      n_cmp++; if (buffer_ready !== 1'b1) begin n_bad++; $display("FAIL const_buffer_ready: got %b want 1", buffer_ready); end
      n_cmp++; if (bus.out_vref !== 1'b0) begin n_bad++; $display("FAIL const_vref_end: got %b want 0", bus.out_vref); end
   endtask

   task automatic test_block();
      src_load(1); empty_mode = 0; ready_mode = 0;
      pulse_start();
      repeat (2) @(negedge clk);
      n_cmp++; if (buffer_ready !== 1'b0) begin n_bad++; $display("FAIL block_br_clear: got %b want 0", buffer_ready); end
      wait_done();
      n_cmp++; if (got.size() !== NO) begin n_bad++; $display("FAIL block_count: got %0d want %0d", got.size(), NO); end
      if (got.size() >= 2) begin
         n_cmp++; if (got[0] !== 8'hFF) begin n_bad++; $display("FAIL block_first: got %h want ff", got[0]); end
         n_cmp++; if (got[1] !== 8'h7F) begin n_bad++; $display("FAIL block_half: got %h want 7f", got[1]); end
      end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL block_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_empty_toggle();
      src_load(0); empty_mode = 1; ready_mode = 0;
      pulse_start();
      wait_done();
      n_cmp++; if (rd_empty_bad !== 0) begin n_bad++; $display("FAIL toggle_rd_empty: got %0d want 0", rd_empty_bad); end
      n_cmp++; if (got.size() !== NO) begin n_bad++; $display("FAIL toggle_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL toggle_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL toggle_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_random();
      src_load(2); empty_mode = 2; ready_mode = 1;
      pulse_start();
      wait_done();
      n_cmp++; if (rd_empty_bad !== 0) begin n_bad++; $display("FAIL rand_rd_empty: got %0d want 0", rd_empty_bad); end
      n_cmp++; if (stab_bad !== 0)     begin n_bad++; $display("FAIL rand_stable: got %0d want 0", stab_bad); end
      n_cmp++; if (got.size() !== NO)  begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (href_cnt !== H) begin n_bad++; $display("FAIL rand_href: got %0d want %0d", href_cnt, H); end
   endtask

   task automatic test_ready_stall();
      src_load(2); empty_mode = 0; ready_mode = 2; stall_left = 10;
      pulse_start();
      wait_done();
      n_cmp++; if (stall_seen !== 10) begin n_bad++; $display("FAIL stall_cycles: got %0d want 10", stall_seen); end
      n_cmp++; if (stall_bad !== 0)   begin n_bad++; $display("FAIL stall_fifo_rd: got %0d want 0", stall_bad); end
      n_cmp++; if (stab_bad !== 0)    begin n_bad++; $display("FAIL stall_stable: got %0d want 0", stab_bad); end
      n_cmp++; if (got.size() !== NO) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
      ready_mode = 0;
   endtask

   task automatic test_reset_midframe();
      src_load(0); empty_mode = 0; ready_mode = 0;
      pulse_start();
      for (int i = 0; i < 5000 && got.size() < W; i++) @(negedge clk);
      repeat (200) @(negedge clk);
      n_cmp++; if (bus.out_vref !== 1'b1) begin n_bad++; $display("FAIL mid_in_band1: got vref %b want 1", bus.out_vref); end
      reset = 1'b0;
      #2;
      n_cmp++; if (bus.out_vref !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_vref: got %b want 0", bus.out_vref); end
      n_cmp++; if (bus.fifo_rd !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_fifo_rd: got %b want 0", bus.fifo_rd); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %h want 00", bus.out_data); end
      n_cmp++; if (buffer_ready !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_br: got %b want 0", buffer_ready); end
      repeat (3) @(negedge clk);
      src_load(0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      pulse_start();
      wait_done();
      n_cmp++; if (got.size() !== NO) begin n_bad++; $display("FAIL mid_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL mid_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      src_load(0); empty_mode = 0; ready_mode = 0;
      pulse_start();
      repeat (300) @(negedge clk);
      pulse_start();
      repeat (400) @(negedge clk);
      pulse_start();
      wait_done();
      repeat (100) @(negedge clk);
      n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL ign_done: got %0d want 1", done_cnt); end
      n_cmp++; if (bus.out_vref !== 1'b0) begin n_bad++; $display("FAIL ign_vref_after: got %b want 0", bus.out_vref); end
      n_cmp++; if (got.size() !== NO)     begin n_bad++; $display("FAIL ign_count: got %0d want %0d", got.size(), NO); end
      for (int i = 0; i < NO && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL ign_pix[%0d]: got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      empty_mode = 0; ready_mode = 0; stall_left = 0;
      src_load(0);
      test_reset();
      test_constant();
      test_block();
      test_empty_toggle();
      test_random();
      test_ready_stall();
      test_reset_midframe();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/frame_downscaler.md
FRAME_DOWNSCALER -- requirements
Module: frame_downscaler

Interface
REQ-001 Parameter SRC_WIDTH, default 736, source pixels per line.
REQ-002 Parameter SRC_HEIGHT, default 480, source lines per frame.
REQ-003 Parameter SCALE_LOG2, default 4, log2 of the block edge (16x16 source block per output pixel).
REQ-004 Parameter WIDTH, default 46, output pixels per row (SRC_WIDTH>>SCALE_LOG2).
REQ-005 Parameter HEIGHT, default 30, output rows per frame (SRC_HEIGHT>>SCALE_LOG2).
REQ-006 Port list, one clock, reset asynchronous and active-low:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to capture one frame.
- fifo_data  in  8  camera FIFO read data, valid the cycle after fifo_rd.
- fifo_empty  in  1  camera FIFO empty.
- fifo_rd  out  1  camera FIFO read strobe.
- out_data  out  8  downscaled pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_href  out  1  high while an output row is being emitted.
- out_vref  out  1  high from frame start until frame completion.
- frame_done  out  1  one-cycle pulse at frame completion.
- buffer_ready  out  1  a complete downscaled frame has been delivered.

Function
REQ-007 The block SHALL implement states IDLE, CAPTURE, EMIT, DONE.
REQ-008 IDLE->CAPTURE on start=1; start SHALL be ignored in all other states.
REQ-009 On IDLE->CAPTURE the block SHALL clear all WIDTH column accumulators (16 bit), the 12-bit horizontal sum, all counters, and buffer_ready.
REQ-010 In CAPTURE, fifo_rd SHALL equal !fifo_empty, gated so that no more than SRC_WIDTH*2^SCALE_LOG2 reads are issued per band.
REQ-011 Each received pixel (cycle after fifo_rd) SHALL advance x (0..SRC_WIDTH-1), then y (0..SRC_HEIGHT-1) on x wrap.
REQ-012 Received pixels SHALL add into the horizontal sum; on x[SCALE_LOG2-1:0] all ones, the sum plus the current pixel SHALL add into accumulator x>>SCALE_LOG2 and the sum SHALL clear.
REQ-013 Arithmetic SHALL be unsigned and non-saturating; maximum accumulator value 65280 fits 16 bits.
REQ-014 CAPTURE->EMIT when the last pixel of a band (x=SRC_WIDTH-1, y[SCALE_LOG2-1:0] all ones) has been accumulated.
REQ-015 In EMIT, fifo_rd SHALL be 0, out_href=1, out_valid=1, out_data=acc[k][15:8] for k=0..WIDTH-1.
REQ-016 k SHALL advance only on out_valid&&out_ready; out_data SHALL remain stable while out_ready=0; acc[k] SHALL clear on transfer.
REQ-017 After the transfer of k=WIDTH-1: EMIT->CAPTURE if band<HEIGHT-1, else EMIT->DONE.
REQ-018 DONE SHALL last one cycle with frame_done=1, set buffer_ready=1, then go to IDLE.
REQ-019 out_vref SHALL be 1 in CAPTURE and EMIT, 0 in IDLE and DONE.
REQ-020 FIFO empty mid-line SHALL stall capture only; results SHALL be independent of empty/ready timing.

Reset
REQ-021 reset=0 SHALL asynchronously force IDLE, all counters and accumulators to 0, and fifo_rd, out_valid, out_href, out_vref, frame_done, buffer_ready, out_data to 0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; the next start SHALL produce a complete, correct frame.

Verification
REQ-023 Constant 0x80 frame, fifo_empty=0, out_ready=1 -> 1380 outputs of 0x80, 30 out_href pulses, one frame_done, buffer_ready=1.
REQ-024 Block (0,0) all 0xFF, rest 0x00 -> first output 0xFF, remaining 1379 outputs 0x00; block (1,0) half rows 0xFF -> second output 0x7F.
REQ-025 fifo_empty toggling every cycle -> fifo_rd never high while fifo_empty=1; outputs identical to REQ-023.
REQ-026 out_ready held 0 for 10 cycles in EMIT -> out_valid=1, out_data stable, fifo_rd=0 throughout; no output lost or duplicated.
REQ-027 reset=0 during band 5, then start -> all outputs 0 during reset; the next frame matches REQ-023.
REQ-028 start pulsed during CAPTURE -> ignored; exactly one frame_done per accepted start.
